rr_lock_arbiter: RTL and testbench

Parametrised round-robin arbiter with multi-beat transaction locking, successor to the fixed-priority 4×8-bit arbiter in the standard library. It merges N ready/valid producer channels of W-bit data onto one consumer port. Priority rotates so the most recently granted channel becomes lowest priority. Once a transaction's first beat is accepted, the grant stays locked to that channel until its `last` beat is accepted. It sits wherever several request sources share one pipeline port, for example memory request or writeback merge points.

---
 rtl/rr_lock_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   Round-robin arbiter with multi-beat transaction locking. It merges up to
//   four ready/valid producer channels of W-bit data onto one consumer port.
//   The most recently granted channel becomes the lowest priority. Once the
//   first beat of a transaction is accepted, the grant stays with that
//   channel until its last beat is accepted.
//
//   Parameters:
//     N  : active channels, 2..4. Ports for channels >= N are ignored, and
//          their ready outputs stay low.
//     W  : data width per channel.
//     CW : width of io_chosen, ceil(log2(N)).
//
//   Ports:
//     clk, reset                 : sole clock; synchronous active-high reset
//     io_in_<i>_valid/bits/last  : producer channel i beat
//     io_in_<i>_ready            : channel i beat accepted this cycle
//     io_out_valid/bits/last     : beat presented to the consumer
//     io_out_ready               : consumer accepts the beat
//     io_chosen                  : index of the granted channel
//     io_locked                  : a multi-beat transaction holds the grant
module rr_lock_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_in_0_valid,
  input  logic [W-1:0]  io_in_0_bits,
  input  logic          io_in_0_last,
  output logic          io_in_0_ready,
  input  logic          io_in_1_valid,
  input  logic [W-1:0]  io_in_1_bits,
  input  logic          io_in_1_last,
  output logic          io_in_1_ready,
  input  logic          io_in_2_valid,
  input  logic [W-1:0]  io_in_2_bits,
  input  logic          io_in_2_last,
  output logic          io_in_2_ready,
  input  logic          io_in_3_valid,
  input  logic [W-1:0]  io_in_3_bits,
  input  logic          io_in_3_last,
  output logic          io_in_3_ready,
  output logic          io_out_valid,
  output logic [W-1:0]  io_out_bits,
  output logic          io_out_last,
  input  logic          io_out_ready,
  output logic [CW-1:0] io_chosen,
  output logic          io_locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;

  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [4*W-1:0] in_bits;
  logic [3:0]     in_ready;

  logic [CW-1:0]  chosen;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_bits;
  logic           fire;

  assign in_valid = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign in_last  = {io_in_3_last,  io_in_2_last,  io_in_1_last,  io_in_0_last};
  assign in_bits  = {io_in_3_bits,  io_in_2_bits,  io_in_1_bits,  io_in_0_bits};

  // Grant selection. Channels are picked out with shifts rather than indexing,
  // so the select logic stays width-clean for every legal N.
  always_comb begin
    logic [3:0]     vshift;
    logic [3:0]     lshift;
    logic [4*W-1:0] bshift;
    int unsigned    idx;
    logic           found;

    chosen = CW'(N - 1);
    found  = 1'b0;
    idx    = 0;
    vshift = '0;
    if (state_q == LOCKED) begin
      chosen = lock_idx_q;
    end else begin
      // Search order ptr+1 .. ptr (mod N). The first valid channel wins.
      for (int unsigned k = 1; k <= N; k++) begin
        idx    = (32'(ptr_q) + k) % N;
        vshift = in_valid >> idx;
        if (!found && vshift[0]) begin
          found  = 1'b1;
          chosen = CW'(idx);
        end
      end
    end

    vshift    = in_valid >> chosen;
    lshift    = in_last >> chosen;
    bshift    = in_bits >> (32'(chosen) * W);
    out_valid = vshift[0];
    out_last  = lshift[0];
    out_bits  = bshift[W-1:0];
  end

  // Ready goes only to the granted channel and does not depend on that
  // channel's own valid.
  assign in_ready = io_out_ready ? (4'b0001 << chosen) : '0;
  assign fire     = out_valid & io_out_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          ptr_d = chosen;
          if (!out_last) begin
            state_d    = LOCKED;
            lock_idx_d = chosen;
          end
        end
        LOCKED: begin
          // ptr already equals lock_idx, so it is left alone here.
          if (out_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= CW'(N - 1);
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign io_out_valid  = out_valid;
  assign io_out_bits   = out_bits;
  assign io_out_last   = out_last;
  assign io_chosen     = chosen;
  assign io_locked     = (state_q == LOCKED);
  assign io_in_0_ready = in_ready[0];
  assign io_in_1_ready = in_ready[1];
  assign io_in_2_ready = in_ready[2];
  assign io_in_3_ready = in_ready[3];

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter
//   Self-checking bench for rr_lock_arbiter with N=4, W=8. A reference model
//   predicts each cycle's outputs. The prediction goes through a scoreboard
//   queue and is compared against the settled DUT outputs. The directed
//   scenarios also check hard constants at their key points.
module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] v;
  logic [3:0] l;
  logic [7:0] b [4];
  logic       out_ready;

  logic       in_ready_0, in_ready_1, in_ready_2, in_ready_3;
  logic       out_valid;
  logic [7:0] out_bits;
  logic       out_last;
  logic [1:0] chosen;
  logic       locked;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(4), .W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_0_valid (v[0]),
    .io_in_0_bits  (b[0]),
    .io_in_0_last  (l[0]),
    .io_in_0_ready (in_ready_0),
    .io_in_1_valid (v[1]),
    .io_in_1_bits  (b[1]),
    .io_in_1_last  (l[1]),
    .io_in_1_ready (in_ready_1),
    .io_in_2_valid (v[2]),
    .io_in_2_bits  (b[2]),
    .io_in_2_last  (l[2]),
    .io_in_2_ready (in_ready_2),
    .io_in_3_valid (v[3]),
    .io_in_3_bits  (b[3]),
    .io_in_3_last  (l[3]),
    .io_in_3_ready (in_ready_3),
    .io_out_valid  (out_valid),
    .io_out_bits   (out_bits),
    .io_out_last   (out_last),
    .io_out_ready  (out_ready),
    .io_chosen     (chosen),
    .io_locked     (locked)
  );

  typedef struct {
    logic [1:0] chosen;
    logic       valid;
    logic [7:0] bits;
    logic       last;
    logic [3:0] rdy;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int n_cmp    = 0;
  int n_err    = 0;
  int fire_cnt = 0;

  // Reference model state, matching the DUT's reset values.
  bit m_locked = 1'b0;
  int m_ptr    = 3;
  int m_lock   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Let the combinational outputs settle, predict them, and compare.
  task automatic settle(input string tag);
    exp_t e;
    exp_t o;
    int   c;
    #1;
    c       = 3;
    e.valid = 1'b0;
    if (m_locked) begin
      c       = m_lock;
      e.valid = v[c];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (v[j]) begin
          c       = j;
          e.valid = 1'b1;
          break;
        end
      end
    end
    e.chosen = 2'(c);
    e.bits   = b[c];
    e.last   = l[c];
    e.rdy    = out_ready ? 4'(1 << c) : 4'b0000;
    e.locked = m_locked;
    sb.push_back(e);

    o   = sb.pop_front();
    cur = o;
    check({tag, "_chosen"}, 32'(chosen), 32'(o.chosen));
    check({tag, "_valid"},  32'(out_valid), 32'(o.valid));
    check({tag, "_bits"},   32'(out_bits), 32'(o.bits));
    check({tag, "_last"},   32'(out_last), 32'(o.last));
    check({tag, "_ready"},  32'({in_ready_3, in_ready_2, in_ready_1, in_ready_0}), 32'(o.rdy));
    check({tag, "_locked"}, 32'(locked), 32'(o.locked));
  endtask

  // Clock edge: advance the model exactly as the DUT should advance.
  task automatic edge_step();
    logic f;
    f = cur.valid & out_ready;
    @(posedge clk);
    if (reset) begin
      m_locked = 1'b0;
      m_ptr    = 3;
      m_lock   = 0;
    end else if (f) begin
      fire_cnt++;
      if (!m_locked) begin
        m_ptr = cur.chosen;
        if (!cur.last) begin
          m_locked = 1'b1;
          m_lock   = cur.chosen;
        end
      end else if (cur.last) begin
        m_locked = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    settle(tag);
    edge_step();
  endtask

  initial begin
    int f0;
    reset     = 1'b1;
    v         = '0;
    l         = '1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) b[i] = 8'(8'h10 + i);
    @(posedge clk);
    @(negedge clk);

    // Reset state: nothing valid, so the chosen index is N-1 and io_locked is 0.
    settle("rst");
    check("rst_chosen_const", 32'(chosen), 3);
    check("rst_locked_const", 32'(locked), 0);
    edge_step();
    reset = 1'b0;

    // 1. Round-robin rotation.
    v         = 4'b1111;
    l         = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle("t1");
      check("t1_rot_chosen", 32'(chosen), 32'(k % 4));
      check("t1_rot_bits",   32'(out_bits), 32'(8'h10 + (k % 4)));
      edge_step();
    end

    // 2. Fairness after a win.
    v = 4'b0100;
    settle("t2a");
    check("t2_first", 32'(chosen), 2);
    edge_step();
    v = 4'b1010;
    settle("t2b");
    check("t2_second", 32'(chosen), 3);
    edge_step();
    settle("t2c");
    check("t2_third", 32'(chosen), 1);
    edge_step();

    // 3 and 4. Lock hold, with a stall in the middle.
    v = 4'b0001;
    step("t3pre");
    v = 4'b0011;
    l = 4'b1101;
    settle("t3b1");
    check("t3_b1_chosen", 32'(chosen), 1);
    check("t3_b1_rdy0", 32'(in_ready_0), 0);
    edge_step();
    settle("t3b2");
    check("t3_b2_chosen", 32'(chosen), 1);
    check("t3_b2_locked", 32'(locked), 1);
    check("t3_b2_rdy0", 32'(in_ready_0), 0);
    edge_step();
    v  = 4'b0001;
    f0 = fire_cnt;
    for (int k = 0; k < 2; k++) begin
      out_ready = (k == 0);
      settle("t4");
      check("t4_out_valid", 32'(out_valid), 0);
      check("t4_other_rdy", 32'({in_ready_3, in_ready_2, in_ready_0}), 0);
      check("t4_locked", 32'(locked), 1);
      edge_step();
    end
    check("t4_no_fire", 32'(fire_cnt - f0), 0);
    out_ready = 1'b1;
    v = 4'b0011;
    l = 4'b1111;
    settle("t3b3");
    check("t3_b3_chosen", 32'(chosen), 1);
    check("t3_b3_rdy0", 32'(in_ready_0), 0);
    edge_step();
    settle("t3post");
    check("t3_post_locked", 32'(locked), 0);
    check("t3_post_chosen", 32'(chosen), 0);
    edge_step();

    // 5. Backpressure.
    v         = 4'b1000;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle("t5");
      check("t5_chosen", 32'(chosen), 3);
      check("t5_rdy3", 32'(in_ready_3), 0);
      edge_step();
    end
    f0        = fire_cnt;
    out_ready = 1'b1;
    settle("t5go");
    check("t5_rdy3_go", 32'(in_ready_3), 1);
    edge_step();
    v = 4'b0000;
    step("t5idle");
    check("t5_one_fire", 32'(fire_cnt - f0), 1);

    // 6. Reset during a lock.
    v = 4'b0100;
    l = 4'b1011;
    step("t6lock");
    v = 4'b0101;
    settle("t6held");
    check("t6_locked", 32'(locked), 1);
    check("t6_chosen", 32'(chosen), 2);
    edge_step();
    reset = 1'b1;
    step("t6rst");
    reset = 1'b0;
    settle("t6after");
    check("t6_after_locked", 32'(locked), 0);
    check("t6_after_chosen", 32'(chosen), 0);
    edge_step();

    // Mixed random traffic, checked against the model only.
    for (int k = 0; k < 40; k++) begin
      v         = 4'($urandom_range(0, 15));
      l         = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
